// File: rtl/game_state_ctrl.sv
// Game flow controller: IDLE/PLAYING/CRASH/GAME_OVER sequencing, score and lives
// bookkeeping, per-frame collision thresholding and the registered output pixel mux.
module game_state_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int CRASH_FRAMES = 60,
    parameter int SCORE_DIV    = 30,
    parameter int COLL_MIN_PIX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        collision_flag,
    input  logic        frame_tick,
    input  logic        video_on,
    input  logic        start_btn,
    input  logic [11:0] bg_pixel,
    input  logic [11:0] cars_pixel,
    input  logic [11:0] game_over_pixel,
    output logic [1:0]  game_state,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic        freeze,
    output logic        crash_pulse,
    output logic [11:0] pixel_out
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_CRASH     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  coll_cnt_q, coll_cnt_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [15:0] crash_cnt_q, crash_cnt_d;
    logic        crash_pulse_q, crash_pulse_d;
    logic [11:0] pixel_q, pixel_d;
    logic        start_prev_q;
    logic        seen_low_q;

    logic        start_edge;
    logic        coll_hit;
    logic [7:0]  coll_eff;
    logic        crash_now;
    logic [1:0]  lives_dec;

    // A start edge needs a genuine low sample since reset, so a button held
    // through reset release is not mistaken for a press.
    assign start_edge = start_btn & ~start_prev_q & seen_low_q;
    assign coll_hit   = collision_flag & video_on & (state_q == ST_PLAYING);
    assign coll_eff   = (coll_hit && coll_cnt_q != 8'hFF) ? coll_cnt_q + 8'd1 : coll_cnt_q;
    assign crash_now  = (state_q == ST_PLAYING) && frame_tick && (coll_eff >= 8'(COLL_MIN_PIX));
    assign lives_dec  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;

    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        lives_d       = lives_q;
        div_cnt_d     = div_cnt_q;
        crash_cnt_d   = crash_cnt_q;
        crash_pulse_d = 1'b0;
        coll_cnt_d    = frame_tick ? 8'd0 : coll_eff;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d     = ST_PLAYING;
                    lives_d     = 2'(LIVES_INIT);
                    score_d     = 16'd0;
                    div_cnt_d   = 16'd0;
                    crash_cnt_d = 16'd0;
                    coll_cnt_d  = 8'd0;
                end
            end
            ST_PLAYING: begin
                if (frame_tick) begin
                    if (crash_now) begin
                        crash_pulse_d = 1'b1;
                        lives_d       = lives_dec;
                        crash_cnt_d   = 16'd0;
                        state_d       = (lives_dec == 2'd0) ? ST_GAME_OVER : ST_CRASH;
                    end else if (div_cnt_q == 16'(SCORE_DIV - 1)) begin
                        div_cnt_d = 16'd0;
                        score_d   = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                    end else begin
                        div_cnt_d = div_cnt_q + 16'd1;
                    end
                end
            end
            ST_CRASH: begin
                if (frame_tick) begin
                    if (crash_cnt_q == 16'(CRASH_FRAMES - 1)) begin
                        crash_cnt_d = 16'd0;
                        state_d     = ST_PLAYING;
                    end else begin
                        crash_cnt_d = crash_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        pixel_d = 12'd0;
        if (video_on) begin
            case (state_q)
                ST_IDLE:    pixel_d = bg_pixel;
                ST_PLAYING: pixel_d = cars_pixel;
                ST_CRASH:   pixel_d = crash_cnt_q[3] ? bg_pixel : cars_pixel;
                default:    pixel_d = (game_over_pixel != 12'd0) ? game_over_pixel : cars_pixel;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            score_q       <= 16'd0;
            lives_q       <= 2'd0;
            coll_cnt_q    <= 8'd0;
            div_cnt_q     <= 16'd0;
            crash_cnt_q   <= 16'd0;
            crash_pulse_q <= 1'b0;
            pixel_q       <= 12'd0;
            start_prev_q  <= 1'b0;
            seen_low_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            coll_cnt_q    <= coll_cnt_d;
            div_cnt_q     <= div_cnt_d;
            crash_cnt_q   <= crash_cnt_d;
            crash_pulse_q <= crash_pulse_d;
            pixel_q       <= pixel_d;
            start_prev_q  <= start_btn;
            if (!start_btn) begin
                seen_low_q <= 1'b1;
            end
        end
    end

    assign game_state  = state_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign freeze      = (state_q != ST_PLAYING);
    assign crash_pulse = crash_pulse_q;
    assign pixel_out   = pixel_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: vector table, hand-written game scenarios and a
// randomized run against a frame-level reference model.
module tb_game_state_ctrl;

    localparam int LIVES_INIT   = 3;
    localparam int CRASH_FRAMES = 60;
    localparam int SCORE_DIV    = 30;
    localparam int COLL_MIN_PIX = 4;

    localparam logic [11:0] BG  = 12'h111;
    localparam logic [11:0] CAR = 12'h222;
    localparam logic [11:0] GOP = 12'h333;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        collision_flag = 1'b0;
    logic        frame_tick = 1'b0;
    logic        video_on = 1'b0;
    logic        start_btn = 1'b0;
    logic [11:0] bg_pixel = BG;
    logic [11:0] cars_pixel = CAR;
    logic [11:0] game_over_pixel = GOP;
    logic [1:0]  game_state;
    logic [15:0] score;
    logic [1:0]  lives;
    logic        freeze;
    logic        crash_pulse;
    logic [11:0] pixel_out;

    int errors = 0;
    int checks = 0;

    game_state_ctrl #(
        .LIVES_INIT  (LIVES_INIT),
        .CRASH_FRAMES(CRASH_FRAMES),
        .SCORE_DIV   (SCORE_DIV),
        .COLL_MIN_PIX(COLL_MIN_PIX)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .collision_flag (collision_flag),
        .frame_tick     (frame_tick),
        .video_on       (video_on),
        .start_btn      (start_btn),
        .bg_pixel       (bg_pixel),
        .cars_pixel     (cars_pixel),
        .game_over_pixel(game_over_pixel),
        .game_state     (game_state),
        .score          (score),
        .lives          (lives),
        .freeze         (freeze),
        .crash_pulse    (crash_pulse),
        .pixel_out      (pixel_out)
    );

    always #5 clk = ~clk;

    // Frame-level reference: state as an integer, score derived from frames survived.
    int          m_state;
    int          m_lives;
    int          m_played;
    int          m_pix;
    int          m_cticks;
    bit          m_prev;
    bit          m_seen_low;
    bit          m_pulse;
    logic [11:0] m_pixel;

    function automatic int m_score();
        int s;
        s = m_played / SCORE_DIV;
        return (s > 65535) ? 65535 : s;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_played = 0; m_pix = 0; m_cticks = 0;
        m_prev = 1'b0; m_seen_low = 1'b0; m_pulse = 1'b0; m_pixel = 12'd0;
    endtask

    task automatic model_step(input logic btn, input logic coll, input logic tick, input logic vid);
        int  pix;
        bit  press;
        if (!vid) m_pixel = 12'd0;
        else begin
            case (m_state)
                0: m_pixel = bg_pixel;
                1: m_pixel = cars_pixel;
                2: m_pixel = ((m_cticks / 8) % 2 == 0) ? cars_pixel : bg_pixel;
                default: m_pixel = (game_over_pixel != 12'd0) ? game_over_pixel : cars_pixel;
            endcase
        end
        press = btn && !m_prev && m_seen_low;
        pix = m_pix + ((coll && vid && m_state == 1) ? 1 : 0);
        if (pix > 255) pix = 255;
        m_pulse = 1'b0;
        case (m_state)
            0: if (press) begin
                m_state = 1; m_lives = LIVES_INIT; m_played = 0; m_cticks = 0; pix = 0;
            end
            1: if (tick) begin
                if (pix >= COLL_MIN_PIX) begin
                    m_pulse = 1'b1;
                    m_lives--;
                    m_cticks = 0;
                    m_state = (m_lives == 0) ? 3 : 2;
                end else begin
                    m_played++;
                end
            end
            2: if (tick) begin
                m_cticks++;
                if (m_cticks == CRASH_FRAMES) begin
                    m_state = 1;
                    m_cticks = 0;
                end
            end
            default: if (press) m_state = 0;
        endcase
        m_pix = tick ? 0 : pix;
        m_prev = btn;
        if (!btn) m_seen_low = 1'b1;
    endtask

    task automatic compare_model();
        check("model_state", 16'(game_state), 16'(m_state));
        check("model_score", score, 16'(m_score()));
        check("model_lives", 16'(lives), 16'(m_lives));
        check("model_freeze", 16'(freeze), 16'(m_state != 1));
        check("model_pulse", 16'(crash_pulse), 16'(m_pulse));
        check("model_pixel", 16'(pixel_out), 16'(m_pixel));
    endtask

    task automatic step(input logic btn, input logic coll, input logic tick, input logic vid);
        start_btn = btn; collision_flag = coll; frame_tick = tick; video_on = vid;
        @(posedge clk);
        model_step(btn, coll, tick, vid);
        #1;
        compare_model();
    endtask

    // Reset is asserted between edges so the output check proves it is asynchronous.
    task automatic do_reset(input logic btn);
        #2;
        reset_n = 1'b0;
        start_btn = btn; collision_flag = 1'b0; frame_tick = 1'b0; video_on = 1'b0;
        model_reset();
        #1;
        check("rst_state", 16'(game_state), 16'd0);
        check("rst_score", score, 16'd0);
        check("rst_lives", 16'(lives), 16'd0);
        check("rst_freeze", 16'(freeze), 16'd1);
        check("rst_pulse", 16'(crash_pulse), 16'd0);
        check("rst_pixel", 16'(pixel_out), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_crash();
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("crash_pulse_seen", 16'(crash_pulse), 16'd1);
    endtask

    task automatic recover();
        repeat (CRASH_FRAMES) step(1'b0, 1'b0, 1'b1, 1'b1);
        check("recover_state", 16'(game_state), 16'd1);
    endtask

    typedef struct {
        logic        btn, coll, tick, vid;
        logic [1:0]  st, lv;
        logic [15:0] sc;
        logic        fz, pl;
        logic [11:0] px;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 1'b1, 1'b0, 12'h000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3, 16'd0, 1'b0, 1'b0, BG};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3, 16'd0, 1'b0, 1'b0, CAR};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 16'd0, 1'b0, 1'b0, CAR};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 16'd0, 1'b0, 1'b0, CAR};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 16'd0, 1'b0, 1'b0, CAR};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd3, 16'd0, 1'b0, 1'b0, 12'h000};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 16'd0, 1'b0, 1'b0, CAR};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd3, 16'd0, 1'b0, 1'b0, 12'h000};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 16'd0, 1'b0, 1'b0, CAR};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 16'd0, 1'b0, 1'b0, CAR};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 2'd2, 16'd0, 1'b1, 1'b1, CAR};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 16'd0, 1'b1, 1'b0, CAR};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 16'd0, 1'b1, 1'b0, CAR};

        do_reset(1'b0);

        // Start, 3-pixel frame without crash, 4-pixel frame with crash, ignored start.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].btn, vecs[i].coll, vecs[i].tick, vecs[i].vid);
            check($sformatf("vec%0d_state", i), 16'(game_state), 16'(vecs[i].st));
            check($sformatf("vec%0d_lives", i), 16'(lives), 16'(vecs[i].lv));
            check($sformatf("vec%0d_score", i), score, vecs[i].sc);
            check($sformatf("vec%0d_freeze", i), 16'(freeze), 16'(vecs[i].fz));
            check($sformatf("vec%0d_pulse", i), 16'(crash_pulse), 16'(vecs[i].pl));
            check($sformatf("vec%0d_pixel", i), 16'(pixel_out), 16'(vecs[i].px));
        end

        // Crash period with collisions injected: blink every 8 frames, resume on 60th tick.
        for (int k = 0; k < CRASH_FRAMES; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            check("blink_pixel", 16'(pixel_out), 16'(((k / 8) % 2 == 0) ? CAR : BG));
            step(1'b0, 1'b1, 1'b1, 1'b1);
            check("crash_hold_state", 16'(game_state), (k == CRASH_FRAMES - 1) ? 16'd1 : 16'd2);
            check("crash_hold_lives", 16'(lives), 16'd2);
        end

        // Score accumulation from a fresh game, then asynchronous reset mid-game.
        do_reset(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("start_state", 16'(game_state), 16'd1);
        for (int t = 1; t <= 150; t++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            if (t == 29) check("score_29", score, 16'd0);
            if (t == 30) check("score_30", score, 16'd1);
            if (t == 61) check("score_61", score, 16'd2);
        end
        check("score_150", score, 16'd5);
        check("pixel_before_rst", 16'(pixel_out), 16'(CAR));
        do_reset(1'b0);

        // Button held high through reset release must not start a game.
        do_reset(1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("held_btn_idle", 16'(game_state), 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("late_start", 16'(game_state), 16'd1);
        check("late_start_lives", 16'(lives), 16'd3);

        // Three crashes end the game; overlay colour, fallback, restart to IDLE.
        do_crash();
        check("crash1_lives", 16'(lives), 16'd2);
        recover();
        do_crash();
        check("crash2_lives", 16'(lives), 16'd1);
        recover();
        do_crash();
        check("go_state", 16'(game_state), 16'd3);
        check("go_lives", 16'(lives), 16'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("go_pixel", 16'(pixel_out), 16'(GOP));
        game_over_pixel = 12'h000;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("go_pixel_fallback", 16'(pixel_out), 16'(CAR));
        game_over_pixel = GOP;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("go_to_idle", 16'(game_state), 16'd0);
        check("idle_freeze", 16'(freeze), 16'd1);

        // Randomized run against the reference model.
        do_reset(1'b0);
        begin
            logic btn;
            btn = 1'b0;
            for (int c = 0; c < 8000; c++) begin
                bg_pixel   = 12'($urandom);
                cars_pixel = 12'($urandom);
                game_over_pixel = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
                if ($urandom_range(0, 24) == 0) btn = ~btn;
                step(btn, ($urandom_range(0, 99) < 40), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
